// File: rtl/kernel_buffer_sequencer.sv
// -----------------------------------------------------------------------------
// kernel_buffer_sequencer
//
// Kernel weight buffer plus read sequencer for the kernel buffer distributor.
// D banks of W-bit weights share a row address. A configured pass walks
// cfg_num_rows consecutive rows starting at cfg_base_addr. Each row is read
// once, then emitted Trc+1 times with bankSelect stepping 0..Trc. The
// distributor uses {Trc, bankSelect} to pick its broadcast bank.
//
// Ports
//   clk, reset                   : clock, synchronous active-high reset
//   wr_en/wr_bank/wr_addr/wr_data: single-word write port. It is usable in
//                                  any state.
//   cfg_valid/cfg_ready          : pass start handshake. cfg_ready is high
//                                  only in IDLE.
//   cfg_trc                      : Trc, the group size minus one
//   cfg_base_addr                : first row address of the pass
//   cfg_num_rows                 : number of rows in the pass. 0 gives an
//                                  empty pass.
//   out_valid/out_ready          : beat handshake toward the distributor
//   out_data                     : one row. Bank i is at [W*(i+1)-1 -: W].
//   out_ctrl                     : {Trc, bankSelect}
//   busy                         : a pass is in progress
//   done                         : one-cycle pulse when a pass completes
// -----------------------------------------------------------------------------
module kernel_buffer_sequencer #(
    parameter int DEPTH = 2,
    parameter int D     = 1 << DEPTH,
    parameter int W     = 16,
    parameter int AW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [DEPTH-1:0]     wr_bank,
    input  logic [AW-1:0]        wr_addr,
    input  logic [W-1:0]         wr_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [DEPTH-1:0]     cfg_trc,
    input  logic [AW-1:0]        cfg_base_addr,
    input  logic [AW-1:0]        cfg_num_rows,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*D-1:0]       out_data,
    output logic [2*DEPTH-1:0]   out_ctrl,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_next;
    logic [DEPTH-1:0]   r_trc, w_trc_next;
    logic [DEPTH-1:0]   r_bs, w_bs_next;
    logic [AW-1:0]      r_row_addr, w_row_addr_next;
    logic [AW-1:0]      r_rows_left, w_rows_left_next;   // rows remaining, including the current one
    logic               w_rd_en;
    logic [W*D-1:0]     w_rd_row;

    // ------------------------------------------------------------------
    // Weight banks. Each bank is a plain array with a registered read, so
    // it maps onto block RAM. The read register is loaded only in FETCH.
    // That holds the row stable through every EMIT beat and stall. It
    // also means a write to that row after FETCH cannot disturb the
    // output. A write to the same row in the FETCH cycle returns the old
    // word (read-before-write).
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < D; gi++) begin : g_bank
            logic [W-1:0] r_mem [0:(1<<AW)-1];
            logic [W-1:0] r_rd_word;

            always_ff @(posedge clk) begin
                if (wr_en && (wr_bank == DEPTH'(gi))) begin
                    r_mem[wr_addr] <= wr_data;
                end
            end

            always_ff @(posedge clk) begin
                if (w_rd_en) begin
                    r_rd_word <= r_mem[r_row_addr];
                end
            end

            assign w_rd_row[W*(gi+1)-1 -: W] = r_rd_word;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_trc       <= '0;
            r_bs        <= '0;
            r_row_addr  <= '0;
            r_rows_left <= '0;
        end else begin
            r_state     <= w_state_next;
            r_trc       <= w_trc_next;
            r_bs        <= w_bs_next;
            r_row_addr  <= w_row_addr_next;
            r_rows_left <= w_rows_left_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_trc_next       = r_trc;
        w_bs_next        = r_bs;
        w_row_addr_next  = r_row_addr;
        w_rows_left_next = r_rows_left;
        w_rd_en          = 1'b0;
        cfg_ready        = 1'b0;
        out_valid        = 1'b0;
        busy             = 1'b1;
        done             = 1'b0;

        case (r_state)
            S_IDLE: begin
                cfg_ready = 1'b1;
                busy      = 1'b0;
                if (cfg_valid) begin
                    w_trc_next       = cfg_trc;
                    w_bs_next        = '0;
                    w_row_addr_next  = cfg_base_addr;
                    w_rows_left_next = cfg_num_rows;
                    w_state_next     = (cfg_num_rows != '0) ? S_FETCH : S_DONE;
                end
            end

            S_FETCH: begin
                w_rd_en      = 1'b1;
                w_state_next = S_EMIT;
            end

            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_bs < r_trc) begin
                        w_bs_next = r_bs + DEPTH'(1);
                    end else if (r_rows_left > AW'(1)) begin
                        // The row address wraps modulo 2^AW.
                        w_bs_next        = '0;
                        w_row_addr_next  = r_row_addr + AW'(1);
                        w_rows_left_next = r_rows_left - AW'(1);
                        w_state_next     = S_FETCH;
                    end else begin
                        w_state_next = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Outputs are zero unless a beat is presented. This gives the
        // required values in reset and makes idle cycles easy to see.
        out_data = out_valid ? w_rd_row : '0;
        out_ctrl = out_valid ? {r_trc, r_bs} : '0;
    end

endmodule

// File: tb/tb_kernel_buffer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_kernel_buffer_sequencer
//
// Scoreboard bench for kernel_buffer_sequencer.
// The bench keeps its own copy of the weight memory. When a pass is
// configured, it expands the pass into the full list of beats: for each row,
// Trc+1 copies with bankSelect 0..Trc. It pushes those beats into a queue.
// A monitor pops one beat on every accepted handshake and compares it. During
// stalls the monitor checks the presented beat against the queue head.
// -----------------------------------------------------------------------------
module tb_kernel_buffer_sequencer;

    localparam int DEPTH = 2;
    localparam int D     = 4;
    localparam int W     = 16;
    localparam int AW    = 8;

    logic                 clk;
    logic                 reset;
    logic                 wr_en;
    logic [DEPTH-1:0]     wr_bank;
    logic [AW-1:0]        wr_addr;
    logic [W-1:0]         wr_data;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [DEPTH-1:0]     cfg_trc;
    logic [AW-1:0]        cfg_base_addr;
    logic [AW-1:0]        cfg_num_rows;
    logic                 out_valid;
    logic                 out_ready;
    logic [W*D-1:0]       out_data;
    logic [2*DEPTH-1:0]   out_ctrl;
    logic                 busy;
    logic                 done;

    kernel_buffer_sequencer #(
        .DEPTH (DEPTH),
        .D     (D),
        .W     (W),
        .AW    (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_bank       (wr_bank),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_trc       (cfg_trc),
        .cfg_base_addr (cfg_base_addr),
        .cfg_num_rows  (cfg_num_rows),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_ctrl      (out_ctrl),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  ctrl;
    } beat_t;

    beat_t        exp_q[$];
    logic [15:0]  mdl [0:3][0:255];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           stall_cnt = 0;
    int           done_cnt  = 0;
    int           rdy_mode  = 0;     // 0: always ready, 1: random, 2: rdy_force
    logic         rdy_force = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expand one pass into its beats, using the current model memory.
    task automatic push_pass(input logic [1:0] trc, input logic [7:0] base, input logic [7:0] rows);
        beat_t bt;
        logic [7:0] a;
        for (int r = 0; r < int'(rows); r++) begin
            a = base + 8'(r);
            for (int b = 0; b <= int'(trc); b++) begin
                bt.data = {mdl[3][a], mdl[2][a], mdl[1][a], mdl[0][a]};
                bt.ctrl = {trc, 2'(b)};
                exp_q.push_back(bt);
            end
        end
    endtask

    // out_ready changes shortly after the rising edge. It stays stable
    // until the next edge.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = rdy_force;
        endcase
    end

    // Monitor: compare every presented beat with the scoreboard head.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_beat: got data %h ctrl %h expected no beat", out_data, out_ctrl);
            end else begin
                check("beat_data", out_data, exp_q[0].data);
                check("beat_ctrl", 64'(out_ctrl), 64'(exp_q[0].ctrl));
                if (out_ready) begin
                    $display("beat data=%h ctrl=%h", out_data, out_ctrl);
                    void'(exp_q.pop_front());
                end else begin
                    stall_cnt++;
                end
            end
        end
    end

    task automatic mem_write(input int b, input int a, input logic [15:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_bank = 2'(b);
        wr_addr = 8'(a);
        wr_data = d;
        mdl[b][a] = d;
    endtask

    // Present a config at a negedge and hold it over one rising edge.
    // The task returns 1 time unit after that edge.
    task automatic accept_cfg(input logic [1:0] trc, input logic [7:0] base, input logic [7:0] rows);
        @(negedge clk);
        check("cfg_ready_before_accept", 64'(cfg_ready), 64'd1);
        cfg_valid     = 1'b1;
        cfg_trc       = trc;
        cfg_base_addr = base;
        cfg_num_rows  = rows;
        push_pass(trc, base, rows);
        $display("cfg trc=%0d base=%0d rows=%0d", trc, base, rows);
        @(posedge clk);
        #1;
        // Scramble the inputs after acceptance. The latched values must be used.
        cfg_valid     = 1'b0;
        cfg_trc       = 2'($urandom);
        cfg_base_addr = 8'($urandom);
        cfg_num_rows  = 8'($urandom);
    endtask

    // Wait for the done pulse, with a bounded wait. Optionally check the
    // full-rate pass timing.
    task automatic wait_done(input int trc, input int rows, input bit timed);
        int n     = 0;
        int first = -1;
        bit got   = 1'b0;
        int limit = rows * (trc + 2) * 8 + 50;
        while (!got && n <= limit) begin
            @(negedge clk);
            if (n == 0 && rows > 0 && !done) check("busy_in_pass", 64'(busy), 64'd1);
            if (out_valid && first < 0) first = n;
            if (done) got = 1'b1;
            else n++;
        end
        check("done_seen", 64'(got), 64'd1);
        check("queue_empty_at_done", 64'(exp_q.size()), 64'd0);
        if (timed) begin
            check("pass_cycles", 64'(n), 64'(rows * (trc + 2)));
            check("first_beat_latency", 64'(first), (rows == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1);
        end
        @(negedge clk);
        check("done_one_cycle", 64'(done), 64'd0);
        check("cfg_ready_after_done", 64'(cfg_ready), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;
        int done_before;
        logic [1:0] t;
        logic [7:0] bs, rw;

        reset         = 1'b1;
        wr_en         = 1'b0;
        wr_bank       = '0;
        wr_addr       = '0;
        wr_data       = '0;
        cfg_valid     = 1'b0;
        cfg_trc       = '0;
        cfg_base_addr = '0;
        cfg_num_rows  = '0;
        out_ready     = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        reset = 1'b0;

        // Fill every row with random data. Then load the row pattern for rows 0..3.
        for (int a = 0; a < 256; a++)
            for (int b = 0; b < 4; b++)
                mem_write(b, a, 16'($urandom));
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++)
                mem_write(b, r, 16'(16'h100 * r + b));
        @(negedge clk);
        wr_en = 1'b0;

        // Basic two-row pass at full rate.
        rdy_mode = 0;
        accept_cfg(2'd3, 8'd0, 8'd2);
        wait_done(3, 2, 1'b1);

        // First beat stalled for 5 cycles.
        rdy_force = 1'b0;
        rdy_mode  = 2;
        stall_cnt = 0;
        accept_cfg(2'd1, 8'd2, 8'd1);
        k = 0;
        guard = 0;
        while (k < 5 && guard < 50) begin
            @(negedge clk);
            if (out_valid) k++;
            guard++;
        end
        rdy_force = 1'b1;
        wait_done(1, 1, 1'b0);
        check("stall_cycles", 64'(stall_cnt), 64'd5);
        rdy_mode = 0;

        // Row address wraps from 255 to 0.
        accept_cfg(2'd0, 8'hFF, 8'd2);
        wait_done(0, 2, 1'b1);

        // Empty pass.
        accept_cfg(2'd2, 8'd10, 8'd0);
        wait_done(2, 0, 1'b1);

        // Reset on the third beat.
        accept_cfg(2'd3, 8'd0, 8'd2);
        k = 0;
        guard = 0;
        while (k < 3 && guard < 50) begin
            @(posedge clk);
            #1;
            if (out_valid) k++;
            guard++;
        end
        check("third_beat_reached", 64'(k), 64'd3);
        reset = 1'b1;
        done_before = done_cnt;
        @(posedge clk);
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_cfg_ready", 64'(cfg_ready), 64'd1);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check("abort_no_done_pulse", 64'(done_cnt), 64'(done_before));
        accept_cfg(2'd3, 8'd4, 8'd1);
        wait_done(3, 1, 1'b1);

        // Writes during a pass. The write to row 1 lands before row 1 is
        // fetched, so it is visible. The write to row 0 lands in the cycle
        // that fetches row 0, so the pass sees the old word.
        mdl[2][1] = 16'hBEEF;
        accept_cfg(2'd3, 8'd0, 8'd2);
        wr_en   = 1'b1;           // FETCH of row 0
        wr_bank = 2'd0;
        wr_addr = 8'd0;
        wr_data = 16'hCAFE;
        @(posedge clk);
        #1;
        wr_bank = 2'd2;           // row 0 EMIT
        wr_addr = 8'd1;
        wr_data = 16'hBEEF;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        mdl[0][0] = 16'hCAFE;
        wait_done(3, 2, 1'b0);
        accept_cfg(2'd0, 8'd0, 8'd1);
        wait_done(0, 1, 1'b1);

        // Randomized passes.
        for (int i = 0; i < 24; i++) begin
            t  = 2'($urandom_range(0, 3));
            bs = 8'($urandom_range(0, 255));
            rw = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            rdy_mode = i % 2;
            accept_cfg(t, bs, rw);
            wait_done(int'(t), int'(rw), (i % 2) == 0);
        end
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
